// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA window path: sizing helper, FSM encoding and
// default sample/filter geometry common with the window buffer.
package cfa_pkg;

  localparam int DEF_DATA_BIT_WIDTH = 8;
  localparam int DEF_FILTER_SIZE    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_READ,
    ST_DRAIN,
    ST_NEXT,
    ST_FIN
  } state_t;

  // Ceiling log2 with a floor of one bit so single-value counters stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/cfa_addr_gen.sv
// Stripe-row / column / tap counters for the column-major window scan, plus the
// frame memory address and end-of-scan flags derived from them.
module cfa_addr_gen
  import cfa_pkg::*;
#(
  parameter int FilterSize = DEF_FILTER_SIZE,
  parameter int ImgWidth   = 64,
  parameter int ImgHeight  = 48,
  parameter int AddrWidth  = clog2(ImgWidth*ImgHeight),
  parameter int RowWidth   = clog2(ImgHeight),
  parameter int ColWidth   = clog2(ImgWidth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_clr,
  input  logic                 stripe_clr,
  input  logic                 adv,
  input  logic                 row_inc,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [RowWidth-1:0]  row,
  output logic [ColWidth-1:0]  col,
  output logic                 last_tap,
  output logic                 last_col,
  output logic                 last_stripe
);

  localparam int TapWidth = clog2(FilterSize);

  logic [RowWidth-1:0] row_reg;
  logic [ColWidth-1:0] col_reg;
  logic [TapWidth-1:0] tap_reg;

  assign last_tap    = (tap_reg == TapWidth'(FilterSize-1));
  assign last_col    = (col_reg == ColWidth'(ImgWidth-1));
  assign last_stripe = (row_reg == RowWidth'(ImgHeight-FilterSize));
  assign row         = row_reg;
  assign col         = col_reg;
  assign mem_addr    = AddrWidth'((int'(row_reg) + int'(tap_reg)) * ImgWidth + int'(col_reg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_reg <= '0;
      col_reg <= '0;
      tap_reg <= '0;
    end else begin
      if (frame_clr) begin
        row_reg <= '0;
      end else if (row_inc) begin
        row_reg <= row_reg + 1'b1;
      end
      if (frame_clr || stripe_clr) begin
        col_reg <= '0;
        tap_reg <= '0;
      end else if (adv) begin
        // The column parks on the last one so an idle address stays in range.
        if (last_tap) begin
          tap_reg <= '0;
          if (!last_col) col_reg <= col_reg + 1'b1;
        end else begin
          tap_reg <= tap_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cfa_window_streamer.sv
// Reads a stored frame and feeds the CFA window buffer in column-major tap order,
// with stall absorption, per-stripe buffer reset and a window-complete flag.
module cfa_window_streamer
  import cfa_pkg::*;
#(
  parameter int DataBitWidth = DEF_DATA_BIT_WIDTH,
  parameter int FilterSize   = DEF_FILTER_SIZE,
  parameter int NoOfChannels = 3,
  parameter int ImgWidth     = 64,
  parameter int ImgHeight    = 48,
  parameter int AddrWidth    = clog2(ImgWidth*ImgHeight)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 stall,
  output logic                                 mem_rd,
  output logic [AddrWidth-1:0]                 mem_addr,
  input  logic [NoOfChannels*DataBitWidth-1:0] mem_rdata,
  output logic [NoOfChannels*DataBitWidth-1:0] d_out,
  output logic                                 en_out,
  output logic                                 buf_rst,
  output logic                                 window_valid,
  output logic [clog2(ImgHeight)-1:0]          win_row,
  output logic [clog2(ImgWidth)-1:0]           win_col,
  output logic                                 busy,
  output logic                                 done
);

  localparam int DataWidth = NoOfChannels*DataBitWidth;
  localparam int RowWidth  = clog2(ImgHeight);
  localparam int ColWidth  = clog2(ImgWidth);

  state_t state_reg, state_next;

  logic                frame_clr, stripe_clr, adv, row_inc;
  logic [RowWidth-1:0] row;
  logic [ColWidth-1:0] col;
  logic                last_tap, last_col, last_stripe;
  logic                rd_win, fire, pipe_empty;

  // Each element in flight carries its pixel, whether it completes a window,
  // and the column it belongs to.
  logic                 rd_pend_reg, rd_win_reg;
  logic [ColWidth-1:0]  rd_col_reg;
  logic                 out_valid_reg, out_win_reg;
  logic [DataWidth-1:0] out_data_reg;
  logic [ColWidth-1:0]  out_col_reg;
  logic                 hold_valid_reg, hold_win_reg;
  logic [DataWidth-1:0] hold_data_reg;
  logic [ColWidth-1:0]  hold_col_reg;
  logic                 window_valid_reg;
  logic [RowWidth-1:0]  win_row_reg;
  logic [ColWidth-1:0]  win_col_reg;

  cfa_addr_gen #(
    .FilterSize (FilterSize),
    .ImgWidth   (ImgWidth),
    .ImgHeight  (ImgHeight),
    .AddrWidth  (AddrWidth),
    .RowWidth   (RowWidth),
    .ColWidth   (ColWidth)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .frame_clr   (frame_clr),
    .stripe_clr  (stripe_clr),
    .adv         (adv),
    .row_inc     (row_inc),
    .mem_addr    (mem_addr),
    .row         (row),
    .col         (col),
    .last_tap    (last_tap),
    .last_col    (last_col),
    .last_stripe (last_stripe)
  );

  assign rd_win     = last_tap && (col >= ColWidth'(FilterSize-1));
  assign fire       = out_valid_reg && !stall;
  assign pipe_empty = !rd_pend_reg && !out_valid_reg && !hold_valid_reg;

  assign en_out       = fire;
  assign d_out        = out_data_reg;
  assign window_valid = window_valid_reg;
  assign win_row      = win_row_reg;
  assign win_col      = win_col_reg;
  assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_FIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    frame_clr  = 1'b0;
    stripe_clr = 1'b0;
    adv        = 1'b0;
    row_inc    = 1'b0;
    mem_rd     = 1'b0;
    buf_rst    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          frame_clr  = 1'b1;
          state_next = ST_CLR;
        end
      end
      ST_CLR: begin
        buf_rst    = 1'b1;
        stripe_clr = 1'b1;
        state_next = ST_READ;
      end
      ST_READ: begin
        // A full hold register means one more return could not be absorbed.
        if (!stall && !hold_valid_reg) begin
          mem_rd = 1'b1;
          adv    = 1'b1;
          if (last_tap && last_col) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (last_stripe) begin
          state_next = ST_FIN;
        end else begin
          row_inc    = 1'b1;
          state_next = ST_CLR;
        end
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_reg      <= 1'b0;
      rd_win_reg       <= 1'b0;
      rd_col_reg       <= '0;
      out_valid_reg    <= 1'b0;
      out_win_reg      <= 1'b0;
      out_data_reg     <= '0;
      out_col_reg      <= '0;
      hold_valid_reg   <= 1'b0;
      hold_win_reg     <= 1'b0;
      hold_data_reg    <= '0;
      hold_col_reg     <= '0;
      window_valid_reg <= 1'b0;
      win_row_reg      <= '0;
      win_col_reg      <= '0;
    end else begin
      rd_pend_reg <= mem_rd;
      if (mem_rd) begin
        rd_win_reg <= rd_win;
        rd_col_reg <= col;
      end
      if (out_valid_reg && stall) begin
        if (rd_pend_reg) begin
          hold_valid_reg <= 1'b1;
          hold_data_reg  <= mem_rdata;
          hold_win_reg   <= rd_win_reg;
          hold_col_reg   <= rd_col_reg;
        end
      end else if (hold_valid_reg) begin
        out_valid_reg  <= 1'b1;
        out_data_reg   <= hold_data_reg;
        out_win_reg    <= hold_win_reg;
        out_col_reg    <= hold_col_reg;
        hold_valid_reg <= rd_pend_reg;
        if (rd_pend_reg) begin
          hold_data_reg <= mem_rdata;
          hold_win_reg  <= rd_win_reg;
          hold_col_reg  <= rd_col_reg;
        end
      end else begin
        out_valid_reg <= rd_pend_reg;
        if (rd_pend_reg) begin
          out_data_reg <= mem_rdata;
          out_win_reg  <= rd_win_reg;
          out_col_reg  <= rd_col_reg;
        end
      end
      window_valid_reg <= fire && out_win_reg;
      if (fire && out_win_reg) begin
        win_row_reg <= row;
        win_col_reg <= out_col_reg - ColWidth'(FilterSize-1);
      end
    end
  end

endmodule

// File: tb/tb_cfa_window_streamer.sv
// Directed bench for cfa_window_streamer on an 8x4 frame with a 3x3 window;
// a scoreboard queue holds every expected push and the window it completes.
module tb_cfa_window_streamer;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int F   = 3;
  localparam int DBW = 8;
  localparam int NCH = 3;
  localparam int DW  = NCH*DBW;
  localparam int AW  = 5;
  localparam int RW  = 2;
  localparam int CW  = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic          win;
    int            row;
    int            col;
  } push_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] d_out;
  logic          en_out, buf_rst, window_valid, busy, done;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;

  int n_cmp = 0;
  int n_bad = 0;
  int push_cnt, bufrst_cnt, wv_cnt, done_cnt, rd_cnt, first_win_push;

  push_t         exp_q[$];
  push_t         mon_e;
  logic          exp_wv = 1'b0;
  logic          next_wv;
  int            exp_wrow, exp_wcol;
  logic [DW-1:0] hist [9];

  always #5 clk = ~clk;

  cfa_window_streamer #(
    .DataBitWidth (DBW),
    .FilterSize   (F),
    .NoOfChannels (NCH),
    .ImgWidth     (W),
    .ImgHeight    (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .d_out        (d_out),
    .en_out       (en_out),
    .buf_rst      (buf_rst),
    .window_valid (window_valid),
    .win_row      (win_row),
    .win_col      (win_col),
    .busy         (busy),
    .done         (done)
  );

  function automatic logic [DW-1:0] word(input int r, input int c);
    logic [7:0] p;
    p = 8'(r*16 + c);
    return {p ^ 8'hFF, p ^ 8'h55, p};
  endfunction

  // Synchronous frame memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= word(int'(mem_addr) / W, int'(mem_addr) % W);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_expected();
    push_t e;
    for (int r = 0; r <= H-F; r++)
      for (int c = 0; c < W; c++)
        for (int t = 0; t < F; t++) begin
          e.data = word(r+t, c);
          e.win  = (t == F-1) && (c >= F-1);
          e.row  = r;
          e.col  = c-F+1;
          exp_q.push_back(e);
        end
  endtask

  task automatic clear_counts();
    push_cnt = 0; bufrst_cnt = 0; wv_cnt = 0; done_cnt = 0; rd_cnt = 0;
    first_win_push = -1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      step();
      i++;
    end
    check("done_timeout", 32'(done_cnt != 0), 32'd1);
    repeat (5) step();
  endtask

  task automatic check_frame_totals(input string tag);
    check({tag, "_pushes"}, 32'(push_cnt), 32'(W*F*(H-F+1)));
    check({tag, "_buf_rst"}, 32'(bufrst_cnt), 32'(H-F+1));
    check({tag, "_windows"}, 32'(wv_cnt), 32'((W-F+1)*(H-F+1)));
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_first_win_push"}, 32'(first_win_push), 32'(F*F));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_wv = 1'b0;
    end else begin
      if (window_valid && first_win_push < 0) first_win_push = push_cnt;
      if (exp_wv) begin
        check("win_row", 32'(win_row), 32'(exp_wrow));
        check("win_col", 32'(win_col), 32'(exp_wcol));
        for (int k = 0; k < F*F; k++)
          check("win_px", 32'(hist[k]), 32'(word(exp_wrow + k % F, exp_wcol + k / F)));
      end
      check("window_valid", 32'(window_valid), 32'(exp_wv));
      next_wv = 1'b0;
      if (en_out) begin
        push_cnt++;
        check("en_with_buf_rst", 32'(buf_rst), 32'd0);
        if (exp_q.size() == 0) begin
          check("extra_push", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("d_out", 32'(d_out), 32'(mon_e.data));
          next_wv  = mon_e.win;
          exp_wrow = mon_e.row;
          exp_wcol = mon_e.col;
        end
        for (int k = 0; k < F*F-1; k++) hist[k] = hist[k+1];
        hist[F*F-1] = d_out;
        $display("txn push %0d d_out=0x%06h", push_cnt, d_out);
      end
      exp_wv = next_wv;
      if (buf_rst) bufrst_cnt++;
      if (window_valid) wv_cnt++;
      if (done) done_cnt++;
      if (stall) check("en_during_stall", 32'(en_out), 32'd0);
      if (mem_rd) begin
        rd_cnt++;
        check("addr_bound", 32'(mem_addr <= AW'(W*H-1)), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    clear_counts();

    // Reset state
    repeat (3) step();
    check("rst_ctrl", 32'({mem_rd, en_out, buf_rst, window_valid, busy, done}), 32'd0);
    check("rst_d_out", 32'(d_out), 32'd0);
    check("rst_win", 32'({win_row, win_col}), 32'd0);
    rst = 1'b1;
    step();

    // Frame 1: unstalled, with cycle-exact checks of the first push
    clear_counts();
    fill_expected();
    pulse_start();
    check("c1_buf_rst", 32'(buf_rst), 32'd1);
    check("c1_busy", 32'(busy), 32'd1);
    check("c1_mem_rd", 32'(mem_rd), 32'd0);
    @(posedge clk); #1;
    check("c2_mem_rd", 32'(mem_rd), 32'd1);
    check("c2_addr", 32'(mem_addr), 32'd0);
    check("c2_buf_rst", 32'(buf_rst), 32'd0);
    @(posedge clk); #1;
    check("c3_addr", 32'(mem_addr), 32'(W));
    check("c3_en_out", 32'(en_out), 32'd0);
    @(posedge clk); #1;
    check("c4_en_out", 32'(en_out), 32'd1);
    check("c4_d_out", 32'(d_out), 32'(word(0, 0)));
    wait_done(1000);
    check_frame_totals("f1");

    // Frame 2: five stall cycles right after the fourth read
    clear_counts();
    fill_expected();
    pulse_start();
    i = 0;
    while (rd_cnt < 4 && i < 50) begin
      step();
      i++;
    end
    check("stall_setup_reads", 32'(rd_cnt), 32'd4);
    @(posedge clk);
    #1 stall = 1'b1;
    repeat (5) @(posedge clk);
    #1 stall = 1'b0;
    check("stall_no_reads", 32'(rd_cnt), 32'd4);
    wait_done(1000);
    check_frame_totals("f2");

    // Frame 3: reset asserted mid-frame, outputs must clear at once
    clear_counts();
    fill_expected();
    pulse_start();
    repeat (30) step();
    rst = 1'b0;
    #1;
    check("midrst_ctrl", 32'({mem_rd, en_out, buf_rst, window_valid, busy, done}), 32'd0);
    check("midrst_d_out", 32'(d_out), 32'd0);
    check("midrst_win", 32'({win_row, win_col}), 32'd0);
    exp_q.delete();
    repeat (3) step();
    rst = 1'b1;
    step();

    // Frame 4: clean frame after reset, with a start pulse while busy
    clear_counts();
    fill_expected();
    pulse_start();
    repeat (20) step();
    check("busy_before_glitch", 32'(busy), 32'd1);
    pulse_start();
    wait_done(1000);
    check_frame_totals("f4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
